// File: rtl/sram_serial_loader_if.sv
// Host-side command/response bus of the serial SRAM loader.
// Groups the parallel command channel (valid/ready, write flag, SRAM
// select, address, write word) and the read response channel
// (valid/ready, read word).
//   master : host that issues commands and consumes responses
//   slave  : sram_serial_loader
interface sram_serial_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic                  cmd_mux;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_mux, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_mux, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_serial_loader.sv
// Serial SRAM loader: owns the BNN top's serial SRAM pins on behalf of the
// host. Parallel write words are shifted out MSB-first on SRAMDIN followed
// by a one-cycle write strobe; reads issue a read strobe, wait RD_WAIT
// cycles and shift SRAMDOUT in MSB-first before presenting a response.
// SRAMSEL is released whenever the loader is idle.
// Ports:
//   CLK, RST       clock, asynchronous active-low reset
//   host           command/response bus (sram_serial_loader_if.slave)
//   busy           loader not idle
//   SRAMSEL        host owns the SRAMs
//   SRAMA/SRAMMUX  address and SRAM select, latched at command accept
//   SRAMCEN/WEN    active-low chip/write enable strobes
//   SRAMDIN        serial write bit
//   SRAMDOUT       serial read bit
//   wr_err         sticky readback mismatch (only with readback enabled)
// Build option: define SRAM_LOADER_READBACK_EN to read back and verify
// every written word.
module sram_serial_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int RD_WAIT    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    sram_serial_loader_if.slave   host,
    output logic                  busy,
    output logic                  SRAMSEL,
    output logic [ADDR_WIDTH-1:0] SRAMA,
    output logic                  SRAMMUX,
    output logic                  SRAMCEN,
    output logic                  SRAMWEN,
    output logic                  SRAMDIN,
    input  logic                  SRAMDOUT
`ifdef SRAM_LOADER_READBACK_EN
    ,
    output logic                  wr_err
`endif
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] INST_LAST = CW'(INST_WIDTH - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
    localparam bit            HAS_WAIT  = (RD_WAIT > 0);
    localparam logic [DATA_WIDTH-1:0] INST_MASK =
        {{(DATA_WIDTH - INST_WIDTH){1'b0}}, {INST_WIDTH{1'b1}}};
`ifdef SRAM_LOADER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, SHIFT_W, WSTROBE, RSTROBE, RWAIT, SHIFT_R, RESP, VERIFY
    } state_t;

    state_t                state_r, state_s;
    logic [CW-1:0]         count_r, count_s;
    logic                  wide_r;       // latched W: 1 = DATA_WIDTH
    logic                  verify_r;     // current read is a write readback
    logic [DATA_WIDTH-1:0] word_r;       // written word, masked to W bits
    logic [DATA_WIDTH-1:0] shreg_r;      // read deserialiser
    logic [DATA_WIDTH-1:0] cmd_word_s;
    logic [CW-1:0]         last_s;
    logic                  accept_s;
    logic                  din_s;

    assign accept_s   = host.cmd_valid && host.cmd_ready;
    assign cmd_word_s = host.cmd_mux ? host.cmd_wdata : (host.cmd_wdata & INST_MASK);
    assign last_s     = wide_r ? DATA_LAST : INST_LAST;

    // Next-state, bit counter and next serial write bit.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        din_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && host.cmd_write) begin
                    state_s = SHIFT_W;
                    count_s = host.cmd_mux ? DATA_LAST : INST_LAST;
                end else if (accept_s) begin
                    state_s = RSTROBE;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT_W: begin
                if (count_r == '0) begin
                    state_s = WSTROBE;
                end else begin
                    count_s = count_r - CW'(1);
                end
            end
            WSTROBE: begin
                state_s = READBACK ? RSTROBE : IDLE;
            end
            RSTROBE: begin
                if (HAS_WAIT) begin
                    state_s = RWAIT;
                    count_s = WAIT_LAST;
                end else begin
                    state_s = SHIFT_R;
                    count_s = last_s;
                end
            end
            RWAIT: begin
                if (count_r == '0) begin
                    state_s = SHIFT_R;
                    count_s = last_s;
                end else begin
                    count_s = count_r - CW'(1);
                end
            end
            SHIFT_R: begin
                if (count_r == '0) begin
                    state_s = verify_r ? VERIFY : RESP;
                end else begin
                    count_s = count_r - CW'(1);
                end
            end
            RESP: begin
                if (host.rsp_valid && host.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            VERIFY: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                count_s = '0;
            end
        endcase
        // On the accept edge the word is not yet latched, so take it from the bus.
        if (state_s == SHIFT_W && state_r == IDLE) begin
            din_s = cmd_word_s[count_s];
        end else if (state_s == SHIFT_W) begin
            din_s = word_r[count_s];
        end else begin
            din_s = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r        <= IDLE;
            count_r        <= '0;
            wide_r         <= 1'b0;
            verify_r       <= 1'b0;
            word_r         <= '0;
            shreg_r        <= '0;
            host.cmd_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
            busy           <= 1'b0;
            SRAMSEL        <= 1'b0;
            SRAMA          <= '0;
            SRAMMUX        <= 1'b0;
            SRAMCEN        <= 1'b1;
            SRAMWEN        <= 1'b1;
            SRAMDIN        <= 1'b0;
`ifdef SRAM_LOADER_READBACK_EN
            wr_err         <= 1'b0;
`endif
        end else begin
            state_r        <= state_s;
            count_r        <= count_s;
            host.cmd_ready <= (state_s == IDLE);
            busy           <= (state_s != IDLE);
            SRAMSEL        <= (state_s != IDLE);
            SRAMCEN        <= !((state_s == WSTROBE) || (state_s == RSTROBE));
            SRAMWEN        <= !(state_s == WSTROBE);
            SRAMDIN        <= din_s;
            if (accept_s) begin
                SRAMA    <= host.cmd_addr;
                SRAMMUX  <= host.cmd_mux;
                wide_r   <= host.cmd_mux;
                verify_r <= READBACK && host.cmd_write;
                word_r   <= cmd_word_s;
            end else begin
                verify_r <= verify_r;
            end
            // Cleared on strobe so short (instruction) reads leave the upper bits zero.
            if (state_s == RSTROBE) begin
                shreg_r <= '0;
            end else if (state_r == SHIFT_R) begin
                shreg_r <= {shreg_r[DATA_WIDTH-2:0], SRAMDOUT};
            end else begin
                shreg_r <= shreg_r;
            end
            // rsp_valid rises one cycle into RESP; ready is only honoured once it is up.
            if (state_r == RESP && !host.rsp_valid) begin
                host.rsp_valid <= 1'b1;
                host.rsp_data  <= shreg_r;
            end else if (host.rsp_valid && host.rsp_ready) begin
                host.rsp_valid <= 1'b0;
            end else begin
                host.rsp_valid <= host.rsp_valid;
            end
`ifdef SRAM_LOADER_READBACK_EN
            if (state_r == VERIFY && shreg_r != word_r) begin
                wr_err <= 1'b1;
            end else if (accept_s && !host.cmd_write && (&host.cmd_addr)) begin
                wr_err <= 1'b0;
            end else begin
                wr_err <= wr_err;
            end
`endif
        end
    end

endmodule
